tomasulo_exe_pipe: RTL

Parametrised, fully pipelined execution unit for the Tomasulo core, replacing the fixed single-result execute stage. Accepts one issued instruction per cycle through a valid/ready handshake and computes the result over a configurable LATENCY_N stages. Results are buffered in an output queue and drained onto the common data bus (CDB) under an arbiter grant, so CDB contention never stalls the pipe. Sits between a reservation station (issue side) and the CDB arbiter (completion side).

---
 rtl/tomasulo_exe_pipe.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/tomasulo_exe_pipe.sv
// Pipelined logic/move execution unit for the Tomasulo core. Results pass through
// LATENCY_N registered stages, the last being an in-order CDB output queue.
package tomasulo_pkg;
   typedef enum logic [2:0] {
      OP_AND  = 3'd0,
      OP_NOT  = 3'd1,
      OP_OR   = 3'd2,
      OP_XOR  = 3'd3,
      OP_MOV0 = 3'd4,
      OP_MOV1 = 3'd5,
      OP_MOVI = 3'd6
   } opcode_t;
endpackage

module tomasulo_exe_pipe
   import tomasulo_pkg::*;
#(
   parameter int W         = 32,
   parameter int IMM_W     = 16,
   parameter int TAG_W     = 4,
   parameter int ROBID_W   = 5,
   parameter int WA_W      = 5,
   parameter int LATENCY_N = 1,
   parameter int Q_N       = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      iss_vld,
   output logic                      iss_rdy,
   input  opcode_t                   iss_op,
   input  logic [W-1:0]              iss_rdata0,
   input  logic [W-1:0]              iss_rdata1,
   input  logic [IMM_W-1:0]          iss_imm,
   input  logic [TAG_W-1:0]          iss_tag,
   input  logic [ROBID_W-1:0]        iss_robid,
   input  logic [WA_W-1:0]           iss_wa,
   output logic                      cdb_vld,
   input  logic                      cdb_gnt,
   output logic [TAG_W-1:0]          cdb_tag,
   output logic [W-1:0]              cdb_wdata,
   output logic [ROBID_W-1:0]        cdb_robid,
   output logic [WA_W-1:0]           cdb_wa,
   output logic [$clog2(Q_N+1)-1:0]  occ
);
   localparam int OCC_W = $clog2(Q_N+1);
   localparam int PTR_W = $clog2(Q_N);

   typedef struct packed {
      logic [TAG_W-1:0]   tag;
      logic [ROBID_W-1:0] robid;
      logic [WA_W-1:0]    wa;
      logic [W-1:0]       data;
   } res_t;

   logic             w_accept;
   logic             w_pop;
   logic             w_wr;
   logic             w_exit_vld;
   logic [W-1:0]     w_result;
   res_t             w_s0;
   res_t             w_exit;
   res_t             w_head;
   logic [OCC_W-1:0] r_occ;
   logic [OCC_W-1:0] r_cnt;
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   res_t             r_q [Q_N];

   // Credits cover in-flight plus queued results, so a pipe exit always finds room.
   assign iss_rdy  = ~flush & (r_occ < OCC_W'(Q_N));
   assign w_accept = iss_vld & iss_rdy;
   assign cdb_vld  = ~flush & (r_cnt != '0);
   assign w_pop    = cdb_vld & cdb_gnt;

   always_comb begin
      w_result = iss_rdata0;
      case (iss_op)
         OP_AND:  w_result = iss_rdata0 & iss_rdata1;
         OP_NOT:  w_result = ~iss_rdata0;
         OP_OR:   w_result = iss_rdata0 | iss_rdata1;
         OP_XOR:  w_result = iss_rdata0 ^ iss_rdata1;
         OP_MOV0: w_result = iss_rdata0;
         OP_MOV1: w_result = iss_rdata1;
         OP_MOVI: w_result = W'(iss_imm);
         default: w_result = iss_rdata0;
      endcase
   end

   assign w_s0 = '{tag: iss_tag, robid: iss_robid, wa: iss_wa, data: w_result};

   generate
      if (LATENCY_N == 1) begin : g_nopipe
         assign w_exit_vld = w_accept;
         assign w_exit     = w_s0;
      end else begin : g_pipe
         logic [LATENCY_N-2:0] r_vld;
         res_t                 r_stage [LATENCY_N-1];

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_vld <= '0;
            end else if (flush) begin
               r_vld <= '0;
            end else begin
               r_vld[0] <= w_accept;
               for (int i = 1; i < LATENCY_N-1; i++) r_vld[i] <= r_vld[i-1];
            end
         end

         always_ff @(posedge clk) begin
            r_stage[0] <= w_s0;
            for (int i = 1; i < LATENCY_N-1; i++) r_stage[i] <= r_stage[i-1];
         end

         assign w_exit_vld = r_vld[LATENCY_N-2];
         assign w_exit     = r_stage[LATENCY_N-2];
      end
   endgenerate

   assign w_wr = w_exit_vld & ~flush;

   always_ff @(posedge clk) begin
      if (w_wr) r_q[r_wptr] <= w_exit;
   end

   assign w_head    = r_q[r_rptr];
   assign cdb_tag   = cdb_vld ? w_head.tag   : '0;
   assign cdb_wdata = cdb_vld ? w_head.data  : '0;
   assign cdb_robid = cdb_vld ? w_head.robid : '0;
   assign cdb_wa    = cdb_vld ? w_head.wa    : '0;
   assign occ       = r_occ;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
         r_occ  <= '0;
      end else if (flush) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
         r_occ  <= '0;
      end else begin
         if (w_wr)  r_wptr <= (r_wptr == PTR_W'(Q_N-1)) ? '0 : r_wptr + 1'b1;
         if (w_pop) r_rptr <= (r_rptr == PTR_W'(Q_N-1)) ? '0 : r_rptr + 1'b1;
         r_cnt <= r_cnt + OCC_W'(w_wr) - OCC_W'(w_pop);
         r_occ <= r_occ + OCC_W'(w_accept) - OCC_W'(w_pop);
      end
   end

   a_occ_bound: assert property (@(posedge clk) disable iff (!rst) r_occ <= OCC_W'(Q_N));
   a_pop_nonempty: assert property (@(posedge clk) disable iff (!rst) w_pop |-> (r_cnt != '0));
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
      (w_wr && !w_pop) |-> (r_cnt < OCC_W'(Q_N)));
   a_cdb_stable: assert property (@(posedge clk) disable iff (!rst)
      (cdb_vld && !cdb_gnt) |=> (flush || $stable({cdb_tag, cdb_wdata, cdb_robid, cdb_wa})));
endmodule
